// File: rtl/decim_ctrl.sv
// Decimation sequencer: word-rate clock, comb tick, integrator flush/settle control
// and a valid/ready word event with sticky overrun, all on the modulator clock.
module decim_ctrl #(
    parameter int MAX_DEC_LOG2 = 8,
    parameter int SETTLE_WORDS = 4
) (
    input  logic       mclkin,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] dec_log2,
    input  logic       cfg_load,
    output logic       word_clk,
    output logic       comb_en,
    output logic       dump,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic [1:0] state,
    output logic [3:0] cur_log2
);
    localparam int CNT_W = MAX_DEC_LOG2 + 1;
    localparam int SET_W = (SETTLE_WORDS < 2) ? 1 : $clog2(SETTLE_WORDS);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_WORDS > 0) ? SETTLE_WORDS - 1 : 0);
    localparam logic [3:0] MAX_RATE = 4'(MAX_DEC_LOG2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] half_cnt;
    logic [3:0]       pend_log2;
    logic             pend_flag;
    logic [SET_W-1:0] settle_cnt;
    logic             at_last;
    logic             at_half;
    logic             tick;
    logic             word_out;

    function automatic logic [3:0] clamp_rate(input logic [3:0] r);
        if (r == 4'd0)
            return 4'd1;
        if (r > MAX_RATE)
            return MAX_RATE;
        return r;
    endfunction

    assign last_cnt = CNT_W'((32'd1 << cur_log2) - 32'd1);
    assign half_cnt = CNT_W'((32'd1 << (cur_log2 - 4'd1)) - 32'd1);
    assign at_last  = (cnt == last_cnt);
    assign at_half  = (cnt == half_cnt);
    // The tick is decided at the wrap edge, so comb_en and out_valid rise together.
    assign tick     = at_last && (st == SETTLE || st == RUN);
    assign word_out = tick && (st == RUN);
    assign state    = st;

    always_ff @(posedge mclkin) begin
        if (rst) begin
            st         <= IDLE;
            cnt        <= '0;
            word_clk   <= 1'b0;
            comb_en    <= 1'b0;
            dump       <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            cur_log2   <= MAX_RATE;
            pend_log2  <= MAX_RATE;
            pend_flag  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            comb_en <= 1'b0;
            if (cfg_load) begin
                pend_log2 <= clamp_rate(dec_log2);
                overrun   <= 1'b0;
            end

            if (!enable || st == IDLE) begin
                if (cfg_load)
                    cur_log2 <= clamp_rate(dec_log2);
                cnt        <= '0;
                word_clk   <= 1'b0;
                out_valid  <= 1'b0;
                pend_flag  <= 1'b0;
                settle_cnt <= '0;
                st         <= enable ? FLUSH : IDLE;
                dump       <= enable;
            end else begin
                cnt     <= at_last ? '0 : cnt + 1'b1;
                comb_en <= tick;
                if (at_last)
                    word_clk <= 1'b0;
                else if (at_half)
                    word_clk <= 1'b1;

                // A new word while the previous one is still unaccepted is lost.
                if (word_out) begin
                    out_valid <= 1'b1;
                    if (out_valid && !out_ready)
                        overrun <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end

                if (at_last) begin
                    if (pend_flag) begin
                        cur_log2   <= pend_log2;
                        st         <= FLUSH;
                        dump       <= 1'b1;
                        pend_flag  <= 1'b0;
                        settle_cnt <= '0;
                    end else if (st == FLUSH) begin
                        dump       <= 1'b0;
                        settle_cnt <= '0;
                        st         <= (SETTLE_WORDS == 0) ? RUN : SETTLE;
                    end else if (st == SETTLE) begin
                        if (settle_cnt == SETTLE_LAST)
                            st <= RUN;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                if (cfg_load)
                    pend_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decim_ctrl.sv
// Bench for decim_ctrl: directed scenarios plus random traffic, with two builds
// (default settle count and zero settle words) tracked by a phase-based reference model.
module tb_decim_ctrl;
    localparam int M_IDLE = 0, M_FLUSH = 1, M_SETTLE = 2, M_RUN = 3;

    logic       mclkin = 1'b0;
    logic       rst, enable, cfg_load, out_ready;
    logic [3:0] dec_log2;

    logic       wclk0, comb0, dump0, vld0, ovr0;
    logic [1:0] st0;
    logic [3:0] cur0;
    logic       wclk1, comb1, dump1, vld1, ovr1;
    logic [1:0] st1;
    logic [3:0] cur1;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cycle_no = 0;

    int m_mode[2], m_phase[2], m_cur[2], m_pend[2], m_left[2];
    bit m_pflag[2], m_tick[2], m_vld[2], m_ovr[2];

    decim_ctrl #(.MAX_DEC_LOG2(8), .SETTLE_WORDS(4)) dut0 (
        .mclkin(mclkin), .rst(rst), .enable(enable), .dec_log2(dec_log2),
        .cfg_load(cfg_load), .word_clk(wclk0), .comb_en(comb0), .dump(dump0),
        .out_valid(vld0), .out_ready(out_ready), .overrun(ovr0), .state(st0),
        .cur_log2(cur0));

    decim_ctrl #(.MAX_DEC_LOG2(8), .SETTLE_WORDS(0)) dut1 (
        .mclkin(mclkin), .rst(rst), .enable(enable), .dec_log2(dec_log2),
        .cfg_load(cfg_load), .word_clk(wclk1), .comb_en(comb1), .dump(dump1),
        .out_valid(vld1), .out_ready(out_ready), .overrun(ovr1), .state(st1),
        .cur_log2(cur1));

    always #5 mclkin = ~mclkin;

    function automatic int clampr(input int r);
        if (r < 1) return 1;
        if (r > 8) return 8;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the position inside the word drives everything; word_clk is
    // simply "second half of the word", a word ends when the phase reaches R-1.
    task automatic model_edge(input int k);
        int r, sw;
        bit eow, word_out, acc;
        sw  = (k == 0) ? 4 : 0;
        acc = m_vld[k] && out_ready;
        m_tick[k] = 0;
        if (rst) begin
            m_mode[k] = M_IDLE; m_phase[k] = 0; m_cur[k] = 8; m_pend[k] = 8;
            m_pflag[k] = 0; m_left[k] = 0; m_vld[k] = 0; m_ovr[k] = 0;
            return;
        end
        if (!enable || m_mode[k] == M_IDLE) begin
            if (cfg_load) begin
                m_cur[k]  = clampr(int'(dec_log2));
                m_pend[k] = m_cur[k];
                m_ovr[k]  = 0;
            end
            m_mode[k]  = enable ? M_FLUSH : M_IDLE;
            m_phase[k] = 0;
            m_vld[k]   = 0;
            m_pflag[k] = 0;
            return;
        end
        r          = 1 << m_cur[k];
        eow        = (m_phase[k] == r - 1);
        m_phase[k] = eow ? 0 : m_phase[k] + 1;
        m_tick[k]  = eow && (m_mode[k] == M_SETTLE || m_mode[k] == M_RUN);
        word_out   = m_tick[k] && (m_mode[k] == M_RUN);
        if (cfg_load) m_ovr[k] = 0;
        if (word_out && m_vld[k] && !out_ready) m_ovr[k] = 1;
        if (word_out) m_vld[k] = 1;
        else if (acc) m_vld[k] = 0;
        if (eow) begin
            if (m_pflag[k]) begin
                m_cur[k] = m_pend[k]; m_mode[k] = M_FLUSH; m_pflag[k] = 0;
            end else if (m_mode[k] == M_FLUSH) begin
                m_left[k] = sw;
                m_mode[k] = (sw == 0) ? M_RUN : M_SETTLE;
            end else if (m_mode[k] == M_SETTLE) begin
                m_left[k]--;
                if (m_left[k] == 0) m_mode[k] = M_RUN;
            end
        end
        if (cfg_load) begin
            m_pend[k]  = clampr(int'(dec_log2));
            m_pflag[k] = 1;
        end
    endtask

    function automatic logic [10:0] exp_vec(input int k);
        logic wc;
        wc = (m_phase[k] >= ((1 << m_cur[k]) / 2));
        return {2'(m_mode[k]), 4'(m_cur[k]), wc, m_tick[k], m_mode[k] == M_FLUSH, m_vld[k], m_ovr[k]};
    endfunction

    task automatic cyc();
        @(posedge mclkin);
        model_edge(0);
        model_edge(1);
        cycle_no++;
        #1;
        chk("lockstep_sw4", {21'd0, st0, cur0, wclk0, comb0, dump0, vld0, ovr0}, {21'd0, exp_vec(0)});
        chk("lockstep_sw0", {21'd0, st1, cur1, wclk1, comb1, dump1, vld1, ovr1}, {21'd0, exp_vec(1)});
    endtask

    // Rise-to-rise measurement of word_clk on the default build.
    task automatic measure_wclk(output int hi, output int per);
        int n, start;
        n = 0; hi = 0;
        while (wclk0 !== 1'b0 && n < 2000) begin n++; cyc(); end
        while (wclk0 !== 1'b1 && n < 2000) begin n++; cyc(); end
        start = cycle_no;
        while (wclk0 === 1'b1 && n < 2000) begin n++; hi++; cyc(); end
        while (wclk0 !== 1'b1 && n < 2000) begin n++; cyc(); end
        per = cycle_no - start;
        chk("wclk_timeout", n < 2000, 1);
    endtask

    initial begin
        int n, ticks, t0, hi, per;
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; dec_log2 = 4'd0; out_ready = 1'b0;
        cyc(); cyc();
        chk("rst_state", st0, 0);
        chk("rst_cur", cur0, 8);
        chk("rst_outs", {wclk0, comb0, dump0, vld0, ovr0}, 0);
        rst = 1'b0;
        cyc();

        // Basic start at the default rate
        dec_log2 = 4'd8; cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("load_idle_cur", cur0, 8);
        enable = 1'b1; out_ready = 1'b1; cyc();
        t0 = cycle_no;
        chk("dump_rise", dump0, 1);
        n = 0;
        while (dump0 === 1'b1 && n < 2000) begin n++; cyc(); end
        chk("dump_len_256", n, 256);
        ticks = 0; n = 0;
        while (vld0 !== 1'b1 && n < 4000) begin
            if (comb0 === 1'b1) ticks++;
            n++; cyc();
        end
        chk("settle_ticks", ticks, 4);
        chk("first_valid_delay", cycle_no - t0, 1536);
        chk("first_valid_comb", comb0, 1);
        t0 = cycle_no; cyc(); n = 0;
        while (vld0 !== 1'b1 && n < 1000) begin n++; cyc(); end
        chk("valid_period_256", cycle_no - t0, 256);
        measure_wclk(hi, per);
        chk("wclk_high_128", hi, 128);
        chk("wclk_period_256", per, 256);

        // Rate change in RUN, loaded mid-word
        dec_log2 = 4'd4; cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("rate_pending_cur", cur0, 8);
        n = 0;
        while (dump0 !== 1'b1 && n < 600) begin n++; cyc(); end
        chk("rate_wait_to_wrap", n, 127);
        chk("rate_applied_cur", cur0, 4);
        n = 0;
        while (dump0 === 1'b1 && n < 200) begin n++; cyc(); end
        chk("dump_len_16", n, 16);
        ticks = 0; n = 0;
        while (vld0 !== 1'b1 && n < 400) begin
            if (comb0 === 1'b1) ticks++;
            n++; cyc();
        end
        chk("settle_ticks_16", ticks, 4);
        t0 = cycle_no; cyc(); n = 0;
        while (comb0 !== 1'b1 && n < 100) begin n++; cyc(); end
        chk("comb_period_16", cycle_no - t0, 16);
        measure_wclk(hi, per);
        chk("wclk_high_8", hi, 8);
        chk("wclk_period_16", per, 16);

        // Backpressure at R=16
        out_ready = 1'b0; n = 0;
        cyc();
        while (comb0 !== 1'b1 && n < 100) begin n++; cyc(); end
        chk("bp_tick1_valid", vld0, 1);
        chk("bp_tick1_ovr", ovr0, 0);
        cyc(); n = 0;
        while (comb0 !== 1'b1 && n < 100) begin n++; cyc(); end
        chk("bp_tick2_valid", vld0, 1);
        chk("bp_tick2_ovr", ovr0, 1);
        repeat (15) cyc();
        out_ready = 1'b1; cyc();
        chk("accept_on_tick_comb", comb0, 1);
        chk("accept_on_tick_valid", vld0, 1);
        chk("accept_on_tick_ovr", ovr0, 1);
        cyc();
        chk("accept_clears_valid", vld0, 0);
        out_ready = 1'b0;
        cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("cfg_clears_ovr", ovr0, 0);

        // Clamping, loaded in IDLE
        enable = 1'b0; cyc();
        chk("disable_idle", st0, 0);
        dec_log2 = 4'd0; cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("clamp_low_cur", cur0, 1);
        enable = 1'b1;
        measure_wclk(hi, per);
        chk("clamp_low_period", per, 2);
        enable = 1'b0; cyc();
        dec_log2 = 4'd12; cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("clamp_high_cur", cur0, 8);

        // Zero-settle build at R=4; default build goes to SETTLE alongside
        dec_log2 = 4'd2; cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        enable = 1'b1; out_ready = 1'b1; cyc();
        t0 = cycle_no;
        chk("sw0_dump_rise", dump1, 1);
        n = 0;
        while (comb1 !== 1'b1 && n < 100) begin n++; cyc(); end
        chk("sw0_first_tick_delay", cycle_no - t0, 8);
        chk("sw0_first_tick_valid", vld1, 1);
        chk("sw4_in_settle", st0, 2);

        // Disable mid-SETTLE
        cyc(); cyc();
        enable = 1'b0; cyc();
        chk("dis_state", st0, 0);
        chk("dis_wclk", wclk0, 0);
        chk("dis_comb", comb0, 0);
        ticks = 0;
        repeat (8) begin cyc(); if (comb0 === 1'b1) ticks++; end
        chk("dis_no_comb", ticks, 0);

        // Reset while in RUN, with overrun set
        enable = 1'b1; out_ready = 1'b0; n = 0;
        while (st0 !== 2'd3 && n < 200) begin n++; cyc(); end
        chk("reach_run", st0, 3);
        repeat (10) cyc();
        chk("pre_rst_ovr", ovr0, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid_rst_state", st0, 0);
        chk("mid_rst_cur", cur0, 8);
        chk("mid_rst_outs", {wclk0, comb0, dump0, vld0, ovr0}, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            enable    = ($urandom_range(0, 149) != 0);
            cfg_load  = ($urandom_range(0, 39) == 0);
            dec_log2  = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 1) == 1;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decim_ctrl.md
Name: decim_ctrl

Overview:
- Sequencer for the sigma-delta decimation path; runs from the modulator master clock.
- Generates the word-rate clock and the one-cycle decimation tick for the comb stage.
- Flushes the integrators and discards settling words after start or a rate change.
- Presents each decimated-word event to the downstream consumer through a valid/ready handshake, with a sticky overrun flag.

Parameters:
- MAX_DEC_LOG2, 8: maximum log2 decimation rate; counter width is MAX_DEC_LOG2+1.
- SETTLE_WORDS, 4: word ticks discarded after flush before data is declared valid; 0 is legal.

Ports:
- mclkin  in  1: master clock; all logic is on its rising edge.
- rst  in  1: synchronous, active-high reset.
- enable  in  1: run request, level-sensitive.
- dec_log2  in  4: requested log2 decimation rate.
- cfg_load  in  1: one-cycle strobe that samples dec_log2.
- word_clk  out  1: word-rate clock, registered.
- comb_en  out  1: one-cycle decimation tick to the comb stage.
- dump  out  1: integrator clear, high throughout FLUSH.
- out_valid  out  1: a decimated word is ready.
- out_ready  in  1: consumer accepts the word.
- overrun  out  1: sticky flag, set when a word was lost.
- state  out  2: 0=IDLE, 1=FLUSH, 2=SETTLE, 3=RUN.
- cur_log2  out  4: rate currently in effect.

Behaviour:
- Reset values:
  - state=IDLE; counter=0.
  - word_clk, comb_en, dump, out_valid and overrun are all 0.
  - cur_log2=MAX_DEC_LOG2; pending rate=MAX_DEC_LOG2; pend_flag=0; settle count=0.
- Rate and counter:
  - R = 1<<cur_log2.
  - Counter counts 0..R-1 and wraps to 0 in FLUSH, SETTLE and RUN.
  - Counter is held at 0 in IDLE.
- Rate clamping: dec_log2 < 1 clamps to 1; dec_log2 > MAX_DEC_LOG2 clamps to MAX_DEC_LOG2.
- word_clk:
  - Set to 1 the cycle after counter==R/2-1; cleared to 0 the cycle after counter==R-1.
  - 50% duty cycle; forced to 0 in IDLE.
- comb_en:
  - High for exactly one cycle, the cycle after counter==R-1, in SETTLE and RUN only.
  - Suppressed in FLUSH and IDLE.
- cfg_load:
  - Clamped dec_log2 is captured as the pending rate.
  - In IDLE it is applied to cur_log2 immediately.
  - Otherwise pend_flag is set and the rate is applied at the next counter wrap (counter==R-1). At that point cur_log2 updates, counter goes to 0 and state goes to FLUSH.
  - A later cfg_load before the wrap overwrites the pending rate (last write wins).
  - cfg_load also clears overrun.
- State transitions:
  - IDLE -> FLUSH when enable=1.
  - FLUSH: dump=1 for one full word (R cycles). At the wrap, go to SETTLE, or to RUN if SETTLE_WORDS=0.
  - SETTLE: counts comb_en ticks. After SETTLE_WORDS ticks, go to RUN. out_valid is never set here.
  - RUN: every comb_en sets out_valid.
  - Any state -> IDLE on the cycle after enable=0. Counter clears, word_clk=0, out_valid=0, pend_flag=0; overrun is kept.
  - Pending rate apply wins over the SETTLE->RUN transition in the same cycle.
- Handshake:
  - out_valid clears on a cycle where out_valid & out_ready.
  - comb_en while out_valid=1 and not being accepted: overrun=1, out_valid stays 1.
  - comb_en in the same cycle as an accept: out_valid stays 1, no overrun.
  - out_ready has no effect while out_valid=0.
- Reset mid-operation: rst overrides all inputs and restores every reset value on the next edge.

Test Plan:
- Basic start, defaults:
  - Stimulus: rst, then cfg_load with dec_log2=8, then enable=1, out_ready=1.
  - Required: dump high for exactly 256 cycles.
  - Required: 4 comb_en pulses with out_valid=0.
  - Required: first out_valid 6*256=1536 cycles after dump rises, repeating every 256 cycles.
  - Required: word_clk period 256 cycles with 128 high.
- Rate change in RUN:
  - Stimulus: cfg_load with dec_log2=4 mid-word.
  - Required: cur_log2 changes at the next wrap; dump high 16 cycles; 4 discarded ticks; then comb_en period 16 and word_clk 8 high / 8 low.
- Clamping:
  - Stimulus: dec_log2=0, then dec_log2=12, each loaded in IDLE.
  - Required: cur_log2 = 1 (word_clk period 2), then cur_log2 = 8.
- Backpressure:
  - Stimulus: RUN at R=16 with out_ready=0.
  - Required: out_valid held at 1; overrun set on the 2nd tick.
  - Stimulus: out_ready=1 exactly on a tick cycle.
  - Required: out_valid stays 1, overrun unchanged.
  - Stimulus: cfg_load.
  - Required: overrun cleared.
- Disable and reset:
  - Stimulus: enable dropped mid-SETTLE.
  - Required: IDLE the next cycle, word_clk=0, no comb_en.
  - Stimulus: rst pulsed while in RUN.
  - Required: all outputs 0, cur_log2=8, state=IDLE.
- SETTLE_WORDS=0 build:
  - Stimulus: enable at R=4.
  - Required: out_valid on the first tick after the 4-cycle flush.
